// File: rtl/score_lives_tracker.sv
// Game-state producer for the score/lives display: saturating score, lives, respawn window, game FSM.
// Optional HIGH_SCORE_EN keeps the best final score across games; otherwise o_hi_score is tied to zero.
module score_lives_tracker #(
  parameter int START_LIVES    = 3,
  parameter int MAX_SCORE      = 99,
  parameter int POINTS_PER_HIT = 1,
  parameter int WAVE_BONUS     = 5,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic       i_frame_tick,
  input  logic       i_start,
  input  logic       i_alien_hit,
  input  logic       i_wave_clear,
  input  logic       i_player_hit,
  output logic [1:0] o_lives,
  output logic [6:0] o_score,
  output logic       o_playing,
  output logic       o_invuln,
  output logic       o_game_over,
  output logic [6:0] o_hi_score
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAYING,
    ST_RESPAWN,
    ST_GAME_OVER
  } state_t;

  localparam logic [1:0] LP_START_LIVES = 2'(START_LIVES);
  localparam logic [7:0] LP_MAX_SCORE   = 8'(MAX_SCORE);
  localparam logic [7:0] LP_PTS_HIT     = 8'(POINTS_PER_HIT);
  localparam logic [7:0] LP_PTS_WAVE    = 8'(WAVE_BONUS);
  localparam logic [7:0] LP_RESPAWN     = 8'(RESPAWN_FRAMES);

  state_t     r_state;
  logic [6:0] r_score;
  logic [1:0] r_lives;
  logic [7:0] r_cnt;
  logic       r_playing;
  logic       r_invuln;
  logic       r_game_over;

  state_t     w_state_nxt;
  logic [6:0] w_score_nxt;
  logic [1:0] w_lives_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_sum;
  logic [6:0] w_score_sat;

  // Sum in 8 bits so the clamp sees the true total rather than a wrapped 7-bit value.
  always_comb begin
    w_sum = {1'b0, r_score}
          + (i_alien_hit  ? LP_PTS_HIT  : 8'd0)
          + (i_wave_clear ? LP_PTS_WAVE : 8'd0);
    w_score_sat = (w_sum > LP_MAX_SCORE) ? LP_MAX_SCORE[6:0] : w_sum[6:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (i_start) begin
          w_score_nxt = 7'd0;
          w_lives_nxt = LP_START_LIVES;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        // Points from this cycle land before the hit is resolved, so a fatal hit keeps them.
        w_score_nxt = w_score_sat;
        if (i_player_hit) begin
          if (r_lives > 2'd1) begin
            w_lives_nxt = r_lives - 2'd1;
            w_cnt_nxt   = LP_RESPAWN;
            w_state_nxt = ST_RESPAWN;
          end else begin
            w_lives_nxt = 2'd0;
            w_state_nxt = ST_GAME_OVER;
          end
        end
      end
      ST_RESPAWN: begin
        w_score_nxt = w_score_sat;
        if (i_frame_tick) begin
          if (r_cnt <= 8'd1) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = ST_PLAYING;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_state     <= ST_IDLE;
      r_score     <= 7'd0;
      r_lives     <= LP_START_LIVES;
      r_cnt       <= 8'd0;
      r_playing   <= 1'b0;
      r_invuln    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_cnt       <= w_cnt_nxt;
      r_playing   <= (w_state_nxt == ST_PLAYING) || (w_state_nxt == ST_RESPAWN);
      r_invuln    <= (w_state_nxt == ST_RESPAWN);
      r_game_over <= (w_state_nxt == ST_GAME_OVER);
    end
  end

`ifdef HIGH_SCORE_EN
  logic [6:0] r_hi_score;
  logic       w_enter_go;

  assign w_enter_go = (r_state != ST_GAME_OVER) && (w_state_nxt == ST_GAME_OVER);

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_hi_score <= 7'd0;
    end else if (w_enter_go && (w_score_nxt > r_hi_score)) begin
      r_hi_score <= w_score_nxt;
    end
  end

  assign o_hi_score = r_hi_score;
`else
  assign o_hi_score = 7'd0;
`endif

  assign o_lives     = r_lives;
  assign o_score     = r_score;
  assign o_playing   = r_playing;
  assign o_invuln    = r_invuln;
  assign o_game_over = r_game_over;

endmodule

// File: doc/score_lives_tracker.md
Name: score_lives_tracker

Overview:
- Game-state producer that drives the lives[1:0] and score[6:0] inputs of the segment display driver.
- Counts alien kills and wave-clear bonuses into a saturating score.
- Decrements lives on player hits and enforces a frame-counted respawn invulnerability window.
- Sequences the game through idle, playing, respawn and game-over states.

Parameters:
- START_LIVES, 3, lives loaded on reset and on game start (1..3).
- MAX_SCORE, 99, score saturation ceiling (≤ 99, so two display digits suffice).
- POINTS_PER_HIT, 1, score added per alien_hit.
- WAVE_BONUS, 5, score added per wave_clear.
- RESPAWN_FRAMES, 60, frame_tick pulses of invulnerability after losing a life (1..255).

Ports:
- clk, input, 1, system clock.
- arst, input, 1, reset: synchronous, active-high (fixed for this block despite the name).
- frame_tick, input, 1, one-cycle pulse per video frame.
- start, input, 1, one-cycle pulse from debounced fire/start button.
- alien_hit, input, 1, one-cycle pulse when a player bullet kills an alien.
- wave_clear, input, 1, one-cycle pulse when the last alien of a wave dies.
- player_hit, input, 1, one-cycle pulse when an alien bullet hits the player.
- lives, output, 2, remaining lives, to display.
- score, output, 7, binary score 0..MAX_SCORE, to display.
- playing, output, 1, high in PLAYING or RESPAWN.
- invuln, output, 1, high in RESPAWN.
- game_over, output, 1, high in GAME_OVER.
- hi_score, output, 7, best final score (see Optional Feature).

Behaviour:

Outputs and reset:
- All outputs are registered and reflect an input event on the clock edge after it is sampled (1-cycle latency).
- On arst: state=IDLE, score=0, lives=START_LIVES, playing=0, invuln=0, game_over=0, respawn counter=0, hi_score=0.
- Reset asserted in any state, including mid-respawn, takes effect on the next edge and overrides all other inputs.

FSM states: IDLE, PLAYING, RESPAWN, GAME_OVER.
- IDLE: hits and wave_clear are ignored. start -> score=0, lives=START_LIVES, go to PLAYING.
- PLAYING:
  - alien_hit and wave_clear add to score (see Score arithmetic).
  - player_hit with lives>1 -> lives-1, load counter=RESPAWN_FRAMES, go to RESPAWN.
  - player_hit with lives==1 -> lives=0, go to GAME_OVER.
  - start is ignored.
- RESPAWN:
  - alien_hit and wave_clear still score; player_hit is ignored.
  - Each frame_tick decrements the counter.
  - When a frame_tick arrives with counter==1, go to PLAYING on that edge, so invuln is high for exactly RESPAWN_FRAMES frame_ticks.
- GAME_OVER: score and lives are frozen; hits are ignored. start -> score=0, lives=START_LIVES, go to PLAYING.

Score arithmetic:
- Compute score + (alien_hit ? POINTS_PER_HIT : 0) + (wave_clear ? WAVE_BONUS : 0) in 8 bits.
- Clamp the result to MAX_SCORE. The score never wraps.

Simultaneous events in one cycle (PLAYING):
- The score update is applied first, then the player_hit handling, in the same edge.
- If that player_hit causes GAME_OVER, the final score includes the points from that cycle.
- Simultaneous start and player_hit in IDLE/GAME_OVER: start wins.

Optional Feature:
- Macro: HIGH_SCORE_EN.
- Defined: on the edge entering GAME_OVER, hi_score <= (final score > hi_score) ? final score : hi_score. hi_score persists across games and is cleared only by arst.
- Undefined: hi_score is tied to 7'd0 and no register is inferred.

Test Plan:
- arst, then 5 alien_hit pulses in IDLE -> score=0, lives=3, playing=0.
- start, then 12 alien_hit and 1 wave_clear -> score=17. Each increment is visible 1 cycle after its pulse.
- start; 20 wave_clear pulses -> score saturates at 99. A further alien_hit plus wave_clear in the same cycle leaves score=99.
- player_hit in PLAYING -> lives=2, invuln=1. Extra player_hit during RESPAWN is ignored. After exactly 60 frame_ticks -> invuln=0, state PLAYING. An alien_hit during RESPAWN raises score by 1.
- Three player_hits (after each respawn expires) with alien_hit coincident on the last -> lives=0, game_over=1, final score includes that hit. start -> score=0, lives=3, playing=1.
- With HIGH_SCORE_EN: game ending at 40 then game ending at 25 -> hi_score=40. arst -> hi_score=0. Without the macro -> hi_score=0 throughout.
